// File: rtl/mem_multi_read_distributed.sv
// Distributed-RAM memory: one byte-enabled write port, NUM_READ_PORTS async read ports, optional 1/2-stage output pipe.
// Define MEM_WRITE_BYPASS_EN to forward an accepted write to read ports addressing the same word.
module mem_multi_read_distributed #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUTPUT_DELAY   = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 init_busy,
    input  logic                                 wea,
    input  logic [AW-1:0]                        addra,
    input  logic [DATA_WIDTH-1:0]                dia,
    input  logic [NB-1:0]                        bea,
    input  logic [NUM_READ_PORTS-1:0]            reb,
    input  logic [NUM_READ_PORTS*AW-1:0]         addrb,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] dob,
    output logic [NUM_READ_PORTS-1:0]            dob_valid
);

    // state | meaning
    // INIT  | clear sweep: ram[cnt_q] <= 0 each cycle, user writes dropped
    // READY | normal operation

    if (OUTPUT_DELAY < 0 || OUTPUT_DELAY > 2) begin : g_bad_delay
        $fatal(1, "OUTPUT_DELAY must be 0, 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "DEPTH must be at least 2");
    end
    if (NUM_READ_PORTS < 1 || NUM_READ_PORTS > 8) begin : g_bad_ports
        $fatal(1, "NUM_READ_PORTS must be 1..8");
    end

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            init_busy_q;
    logic            wr_accept;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data [NUM_READ_PORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q     <= READY;
                        init_busy_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;
    assign wr_accept = wea & ~init_busy_q & ~reset;

    // RAM has no reset of its own; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                ram[cnt_q] <= '0;
            end else if (wr_accept) begin
                for (int j = 0; j < NB; j++) begin
                    if (bea[j]) begin
                        ram[addra][j*BYTE_WIDTH +: BYTE_WIDTH] <= dia[j*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

`ifdef MEM_WRITE_BYPASS_EN
    logic [DATA_WIDTH-1:0] wr_merged;

    always_comb begin
        wr_merged = ram[addra];
        for (int j = 0; j < NB; j++) begin
            if (bea[j]) begin
                wr_merged[j*BYTE_WIDTH +: BYTE_WIDTH] = dia[j*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            rd_data[i] = ram[addrb[i*AW +: AW]];
            if (wr_accept && (addrb[i*AW +: AW] == addra)) begin
                rd_data[i] = wr_merged;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            rd_data[i] = ram[addrb[i*AW +: AW]];
        end
    end
`endif

    if (OUTPUT_DELAY == 0) begin : g_comb
        for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
            assign dob[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i];
        end
        assign dob_valid = reb & {NUM_READ_PORTS{~init_busy_q}};
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0]     s1_q [NUM_READ_PORTS];
        logic [NUM_READ_PORTS-1:0] v1_q;

        // Stage 1 holds its data while reb is low; only the valid drops.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    s1_q[i] <= '0;
                end
                v1_q <= '0;
            end else begin
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (reb[i]) begin
                        s1_q[i] <= rd_data[i];
                    end
                    v1_q[i] <= reb[i] & ~init_busy_q;
                end
            end
        end

        if (OUTPUT_DELAY == 1) begin : g_one
            for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
                assign dob[i*DATA_WIDTH +: DATA_WIDTH] = s1_q[i];
            end
            assign dob_valid = v1_q;
        end else begin : g_two
            logic [DATA_WIDTH-1:0]     s2_q [NUM_READ_PORTS];
            logic [NUM_READ_PORTS-1:0] v2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NUM_READ_PORTS; i++) begin
                        s2_q[i] <= '0;
                    end
                    v2_q <= '0;
                end else begin
                    for (int i = 0; i < NUM_READ_PORTS; i++) begin
                        s2_q[i] <= s1_q[i];
                    end
                    v2_q <= v1_q;
                end
            end

            for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
                assign dob[i*DATA_WIDTH +: DATA_WIDTH] = s2_q[i];
            end
            assign dob_valid = v2_q;
        end
    end

endmodule

// File: tb/tb_mem_multi_read_distributed.sv
// Bench for mem_multi_read_distributed: three instances (read latency 0, 1, 2) share one stimulus stream.
module tb_mem_multi_read_distributed;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic [3:0]    bea;
    logic [NP-1:0] reb;
    logic [NP*AW-1:0] addrb;

    logic             busy0, busy1, busy2;
    logic [NP*DW-1:0] dob0, dob1, dob2;
    logic [NP-1:0]    val0, val1, val2;

    mem_multi_read_distributed #(.OUTPUT_DELAY(0)) u_d0 (
        .clk(clk), .reset(reset), .init_busy(busy0), .wea(wea), .addra(addra), .dia(dia),
        .bea(bea), .reb(reb), .addrb(addrb), .dob(dob0), .dob_valid(val0));
    mem_multi_read_distributed #(.OUTPUT_DELAY(1)) u_d1 (
        .clk(clk), .reset(reset), .init_busy(busy1), .wea(wea), .addra(addra), .dia(dia),
        .bea(bea), .reb(reb), .addrb(addrb), .dob(dob1), .dob_valid(val1));
    mem_multi_read_distributed #(.OUTPUT_DELAY(2)) u_d2 (
        .clk(clk), .reset(reset), .init_busy(busy2), .wea(wea), .addra(addra), .dia(dia),
        .bea(bea), .reb(reb), .addrb(addrb), .dob(dob2), .dob_valid(val2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          dly;
        int          port;
        logic [31:0] data;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [64];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] dob_of(input int d, input int p);
        case (d)
            0:       return dob0[p*DW +: DW];
            1:       return dob1[p*DW +: DW];
            default: return dob2[p*DW +: DW];
        endcase
    endfunction

    function automatic logic val_of(input int d, input int p);
        case (d)
            0:       return val0[p];
            1:       return val1[p];
            default: return val2[p];
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) if (be[j]) r[j*8 +: 8] = nw[j*8 +: 8];
        return r;
    endfunction

    task automatic check_due();
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].due == cyc) begin
                chk({sbq[k].tag, "_data"}, dob_of(sbq[k].dly, sbq[k].port), sbq[k].data);
                chk({sbq[k].tag, "_valid"}, {31'b0, val_of(sbq[k].dly, sbq[k].port)}, {31'b0, sbq[k].valid});
                sbq.delete(k);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_due();
        @(posedge clk);
        #1;
    endtask

    // Read issued this cycle: seen now at latency 0, next cycle at 1, the one after at 2.
    task automatic expect_read(input string tag, input int port, input logic [31:0] data, input logic valid);
        for (int d = 0; d < 3; d++)
            sbq.push_back('{cyc + d, d, port, data, valid,
                            $sformatf("%s_d%0d_p%0d", tag, d, port)});
    endtask

    // reb dropped this cycle: pipelined outputs keep the captured word with valid low.
    task automatic expect_hold(input string tag, input int port, input logic [31:0] held, input logic [31:0] live);
        sbq.push_back('{cyc, 0, port, live, 1'b0, $sformatf("%s_d0_p%0d", tag, port)});
        sbq.push_back('{cyc + 1, 1, port, held, 1'b0, $sformatf("%s_d1_p%0d", tag, port)});
        sbq.push_back('{cyc + 2, 2, port, held, 1'b0, $sformatf("%s_d2_p%0d", tag, port)});
    endtask

    task automatic set_rd(input int a0, input int a1, input logic [1:0] en);
        addrb = {AW'(a1), AW'(a0)};
        reb   = en;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        wea = 1'b1; addra = AW'(a); dia = d; bea = be;
        model[a] = merge(model[a], d, be);
        tick();
        wea = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (busy1 === 1'b1 && n < 200) begin
            n++;
            if (n == 2) wea = 1'b0;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 64);
        chk({tag, "_busy0_low"}, {31'b0, busy0}, 32'd0);
        chk({tag, "_busy2_low"}, {31'b0, busy2}, 32'd0);
        for (int a = 0; a < 64; a++) model[a] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e;
        reset = 1'b1; wea = 1'b0; addra = '0; dia = '0; bea = '0; reb = '0; addrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", {31'b0, busy0}, 32'd1);
        chk("rst_busy1", {31'b0, busy1}, 32'd1);
        chk("rst_busy2", {31'b0, busy2}, 32'd1);
        chk("rst_dob1", dob1[31:0], 32'd0);
        chk("rst_dob2", dob2[63:32], 32'd0);
        chk("rst_val", {26'b0, val0, val1, val2}, 32'd0);

        // Sweep length, then every word reads back as zero
        reset = 1'b0;
        wait_init("init1");
        for (int a = 0; a < 64; a++) begin
            set_rd(a, 63 - a, 2'b11);
            expect_read("clr", 0, model[a], 1'b1);
            expect_read("clr", 1, model[63 - a], 1'b1);
            tick();
        end
        reb = '0;
        tick(); tick();

        // Byte-lane merge
        do_write(5, 32'hAABBCCDD, 4'b1111);
        do_write(5, 32'h11223344, 4'b0101);
        set_rd(5, 5, 2'b11);
        expect_read("merge", 0, 32'hAA22CC44, 1'b1);
        expect_read("same_addr", 1, 32'hAA22CC44, 1'b1);
        tick();

        // One-cycle read burst then hold
        do_write(3, 32'h12, 4'b1111);
        do_write(9, 32'h34, 4'b1111);
        set_rd(3, 9, 2'b11);
        expect_read("burst", 0, 32'h12, 1'b1);
        expect_read("burst", 1, 32'h34, 1'b1);
        tick();
        reb = 2'b00;
        expect_hold("hold", 0, 32'h12, model[3]);
        expect_hold("hold", 1, 32'h34, model[9]);
        tick(); tick(); tick();

        // Read-during-write, full word then partial lanes
        wea = 1'b1; addra = 6'd7; dia = 32'hDEADBEEF; bea = 4'b1111;
        set_rd(7, 5, 2'b11);
`ifdef MEM_WRITE_BYPASS_EN
        e = merge(model[7], 32'hDEADBEEF, 4'b1111);
`else
        e = model[7];
`endif
        expect_read("rdw", 0, e, 1'b1);
        expect_read("rdw_other", 1, model[5], 1'b1);
        model[7] = merge(model[7], 32'hDEADBEEF, 4'b1111);
        tick();
        wea = 1'b0;
        set_rd(7, 7, 2'b11);
        expect_read("after_w", 0, 32'hDEADBEEF, 1'b1);
        expect_read("after_w", 1, 32'hDEADBEEF, 1'b1);
        tick();
        wea = 1'b1; addra = 6'd5; dia = 32'h5566EE77; bea = 4'b0011;
        set_rd(3, 5, 2'b11);
`ifdef MEM_WRITE_BYPASS_EN
        e = merge(model[5], 32'h5566EE77, 4'b0011);
`else
        e = model[5];
`endif
        expect_read("rdw_part", 1, e, 1'b1);
        expect_read("rdw_part_o", 0, model[3], 1'b1);
        model[5] = merge(model[5], 32'h5566EE77, 4'b0011);
        tick();
        wea = 1'b0;
        set_rd(5, 9, 2'b11);
        expect_read("part_vis", 0, 32'hAA22EE77, 1'b1);
        expect_read("part_vis9", 1, model[9], 1'b1);
        tick();
        reb = '0;
        tick(); tick(); tick();

        // Reset in READY with a coincident write, then mid-sweep restart
        reset = 1'b1; wea = 1'b1; addra = 6'd2; dia = 32'h0BADF00D; bea = 4'b1111;
        @(posedge clk); #1;
        wea = 1'b0;
        chk("rdy_rst_busy", {31'b0, busy1}, 32'd1);
        chk("rdy_rst_val", {28'b0, val1, val2}, 32'd0);
        chk("rdy_rst_dob1", dob1[31:0], 32'd0);
        chk("rdy_rst_dob2", dob2[31:0], 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        chk("mid_busy", {31'b0, busy1}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wea = 1'b1; addra = 6'd2; dia = 32'hCAFEF00D; bea = 4'b1111;
        set_rd(63, 63, 2'b01);
        expect_read("busy_rd", 0, 32'd0, 1'b0);
        wait_init("init2");
        reb = '0;
        tick();
        set_rd(2, 5, 2'b11);
        expect_read("reclr", 0, model[2], 1'b1);
        expect_read("reclr", 1, model[5], 1'b1);
        tick();
        set_rd(7, 9, 2'b11);
        expect_read("reclr2", 0, model[7], 1'b1);
        expect_read("reclr2", 1, model[9], 1'b1);
        tick();
        reb = '0;
        tick(); tick(); tick();
        chk("sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_multi_read_distributed.md
MEM_MULTI_READ_DISTRIBUTED -- requirements
Module: mem_multi_read_distributed

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, words; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, independent read ports (1..8).
REQ-004 SHALL have parameter BYTE_WIDTH, default 8; NB = DATA_WIDTH/BYTE_WIDTH byte lanes.
REQ-005 SHALL have parameter OUTPUT_DELAY, default 1, read latency in cycles (0, 1 or 2).
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: init_busy  out  1  high while post-reset clear sweep runs.
REQ-009 SHALL have ports: wea  in  1  write enable; addra  in  AW; dia  in  DATA_WIDTH; bea  in  NB  byte enables.
REQ-010 SHALL have ports: reb  in  NUM_READ_PORTS  per-port read enable (used when OUTPUT_DELAY>0).
REQ-011 SHALL have ports: addrb  in  NUM_READ_PORTS*AW, port i at slice [i*AW +: AW].
REQ-012 SHALL have ports: dob  out  NUM_READ_PORTS*DATA_WIDTH, port i at slice [i*DATA_WIDTH +: DATA_WIDTH]; dob_valid  out  NUM_READ_PORTS.

Function
REQ-013 SHALL store DEPTH x DATA_WIDTH words in distributed (LUT) RAM, single write port, NUM_READ_PORTS asynchronous read ports.
REQ-014 SHALL write byte lane j of dia to ram[addra] at the clock edge when wea=1, bea[j]=1, init_busy=0; lanes with bea[j]=0 unchanged.
REQ-015 SHALL implement FSM states INIT and READY; reset -> INIT with sweep counter 0.
REQ-016 In INIT SHALL write 0 to ram[counter] each cycle, increment counter, go READY after address DEPTH-1 is cleared (exactly DEPTH cycles); init_busy=1 throughout INIT.
REQ-017 SHALL ignore wea while init_busy=1; user write is dropped, not queued.
REQ-018 OUTPUT_DELAY=0: dob port i = ram[addrb_i] combinationally; dob_valid[i] = reb[i] & ~init_busy.
REQ-019 OUTPUT_DELAY=1: on edge with reb[i]=1 stage1 captures ram[addrb_i], valid1[i] <= reb[i] & ~init_busy; reb[i]=0 holds stage1 data, clears valid1[i].
REQ-020 OUTPUT_DELAY=2: stage2 <= stage1 and valid2 <= valid1 every cycle; dob/dob_valid driven from stage2.
REQ-021 Read and write same address same cycle without bypass SHALL return pre-write contents; write visible from next cycle.
REQ-022 Ports reading the same address simultaneously SHALL all return identical data.
REQ-023 Parameter violations (OUTPUT_DELAY outside 0..2, DATA_WIDTH not multiple of BYTE_WIDTH, DEPTH<2, NUM_READ_PORTS outside 1..8) SHALL $fatal at elaboration.

Reset
REQ-024 reset=1 at an edge SHALL clear stage1/stage2 data and valids to 0, dob_valid=0, and force INIT with counter 0.
REQ-025 Reset asserted mid-INIT SHALL restart sweep at address 0; reset asserted in READY SHALL re-clear whole memory.
REQ-026 Write coincident with reset SHALL be dropped.
REQ-027 After reset deassertion dob SHALL read 0 for all addresses once READY.

Configuration
REQ-028 Macro MEM_WRITE_BYPASS_EN, when defined, SHALL forward merged write data (dia on enabled lanes, old ram bytes elsewhere) to any read port whose addrb equals addra while a write is accepted that cycle.
REQ-029 Without MEM_WRITE_BYPASS_EN, SHALL follow REQ-021 (old data); no forwarding logic synthesised.

Verification
REQ-030 Reset, DEPTH=64: init_busy high exactly 64 cycles then low; read all addresses -> 0, dob_valid=1 when reb=1.
REQ-031 Write addr 5 dia=0xAABBCCDD bea=4'b1111, then addr 5 dia=0x11223344 bea=4'b0101 -> port0 reads 0xAA22CC44.
REQ-032 OUTPUT_DELAY=2, port0 addr 3 (0x12), port1 addr 9 (0x34), reb=2'b11 one cycle -> 0x12/0x34 with dob_valid=2'b11 two edges later, then valid 0.
REQ-033 Write addr 7 dia=0xDEADBEEF and read addr 7 same cycle, delay 0: no bypass -> old 0x0; with MEM_WRITE_BYPASS_EN -> 0xDEADBEEF.
REQ-034 Assert reset at sweep cycle 30, release -> init_busy high 64 more cycles; write during INIT to addr 2 dropped, reads 0.
REQ-035 OUTPUT_DELAY=1, reb[0]=1 then 0 -> dob held at captured value, dob_valid[0] drops after one cycle.
